// File: rtl/flag_branch_if.sv
// Consumer-side ALU flag interface: flag/branch/interrupt controls in,
// condition-code register state and branch/flush status out.
interface flag_branch_if;
    logic [3:0] alu_flags;
    logic       flag_we;
    logic       branch_valid;
    logic [1:0] branch_type;
    logic       int_save;
    logic       int_restore;
    logic [3:0] flags_q;
    logic       branch_taken;
    logic       flush;
    logic       busy;
    logic       saved_valid;

    modport master (
        output alu_flags, flag_we, branch_valid, branch_type, int_save, int_restore,
        input  flags_q, branch_taken, flush, busy, saved_valid
    );

    modport slave (
        input  alu_flags, flag_we, branch_valid, branch_type, int_save, int_restore,
        output flags_q, branch_taken, flush, busy, saved_valid
    );
endinterface

// File: rtl/flag_branch_unit.sv
// Condition-code register with branch resolution, post-branch flush sequencing
// and single-level interrupt save/restore of the flags.
module flag_branch_unit #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    flag_branch_if.slave      bus
);
    typedef enum logic {IDLE, FLUSH} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] ccr_q, ccr_d;
    logic [3:0] snap_q, snap_d;
    logic       saved_valid_q, saved_valid_d;
    logic       taken_q, taken_d;

    logic       cond_met;
    logic       restore_hit;
    logic [3:0] ccr_base;
    logic [3:0] clr_mask;

    always_comb begin
        cond_met = 1'b0;
        clr_mask = 4'b0000;
        unique case (bus.branch_type)
            2'b00: begin cond_met = ccr_q[0]; clr_mask = 4'b0001; end
            2'b01: begin cond_met = ccr_q[1]; clr_mask = 4'b0010; end
            2'b10: begin cond_met = ccr_q[2]; clr_mask = 4'b0100; end
            default: begin cond_met = 1'b1; clr_mask = 4'b0000; end
        endcase
    end

    // Restore beats ALU write; the taken-branch clear is applied on top of either.
    assign restore_hit = bus.int_restore && saved_valid_q;
    assign ccr_base    = restore_hit ? snap_q :
                         bus.flag_we ? bus.alu_flags : ccr_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        taken_d       = 1'b0;
        ccr_d         = ccr_base;
        snap_d        = snap_q;
        saved_valid_d = saved_valid_q;

        unique case (state_q)
            IDLE: begin
                if (bus.branch_valid && cond_met) begin
                    taken_d = 1'b1;
                    ccr_d   = ccr_base & ~clr_mask;
                    state_d = FLUSH;
                    cnt_d   = CNT_LOAD;
                end
            end
            FLUSH: begin
                // Branches arriving here belong to squashed instructions.
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        if (restore_hit) begin
            saved_valid_d = 1'b0;
        end else if (bus.int_save) begin
            snap_d        = ccr_q;
            saved_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            ccr_q         <= 4'd0;
            snap_q        <= 4'd0;
            saved_valid_q <= 1'b0;
            taken_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ccr_q         <= ccr_d;
            snap_q        <= snap_d;
            saved_valid_q <= saved_valid_d;
            taken_q       <= taken_d;
        end
    end

    assign bus.flags_q      = ccr_q;
    assign bus.branch_taken = taken_q;
    assign bus.flush        = (state_q == FLUSH);
    assign bus.busy         = (state_q == FLUSH);
    assign bus.saved_valid  = saved_valid_q;
endmodule

// File: doc/flag_branch_unit.md
# flag_branch_unit

Condition-code register and branch resolver on the consumer side of the ALU flag interface. Captures the ALU's zero/negative/carry flags, feeds them back as the ALU flag input, evaluates conditional jumps against them, and consumes the tested flag on a taken jump. Issues a fixed-length pipeline flush after every taken branch. Saves and restores the flags across interrupt entry and return.

## Interface
- FLUSH_CYCLES, default 2: number of cycles `flush` stays high after a taken branch. Legal range is 1 to 15.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- alu_flags  in  4  flags from the ALU. bit0 = Z, bit1 = N, bit2 = C, bit3 = reserved.
- flag_we  in  1  load `alu_flags` into the condition-code register (CCR) this cycle.
- branch_valid  in  1  a branch instruction is presented this cycle.
- branch_type  in  2  branch kind: 00 = JZ, 01 = JN, 10 = JC, 11 = JMP (unconditional).
- int_save  in  1  interrupt entry; snapshot the CCR.
- int_restore  in  1  return from interrupt; reload the CCR from the snapshot.
- flags_q  out  4  current CCR; drives the ALU `flags_in`.
- branch_taken  out  1  one-cycle pulse: the branch was taken.
- flush  out  1  squash younger pipeline stages.
- busy  out  1  high while in FLUSH; branches are not accepted.
- saved_valid  out  1  a snapshot is held.

## Operation
- **State machine:** two states, IDLE and FLUSH, plus a 4-bit flush counter `cnt`.
- **Branch accept:** a branch is accepted only in IDLE, when `branch_valid` = 1.
- **Branch decision:** taken = (JZ & Z) | (JN & N) | (JC & C) | JMP, evaluated on the current `flags_q` (pre-update value).
- **Taken branch:**
  - Transition IDLE -> FLUSH, load `cnt` = FLUSH_CYCLES - 1.
  - Clear the tested flag: JZ clears Z, JN clears N, JC clears C. JMP clears nothing.
- **Not-taken branch:** stay in IDLE, no flag change.
- **FLUSH state:**
  - `branch_valid` is ignored (it belongs to a squashed instruction).
  - `cnt` decrements each cycle; at `cnt` = 0, transition FLUSH -> IDLE.
- **CCR next-value priority** (the branch clear is applied last, on the result):
  1. `int_restore` with `saved_valid` = 1: CCR <= snapshot; `saved_valid` <= 0.
  2. Else `flag_we`: CCR <= `alu_flags`.
  3. Else: hold.
- **Branch clear vs. ALU write:** the flag clear from a taken branch overrides a same-cycle `flag_we` for that bit only.
- **Interrupt save:** `int_save` loads snapshot <= current `flags_q` and sets `saved_valid` <= 1. A second save overwrites the snapshot (single level, no nesting).
- **Save and restore in the same cycle:** restore wins; the save is ignored.
- **Restore with no snapshot:** `int_restore` when `saved_valid` = 0 leaves the CCR unchanged. If `flag_we` is also high that cycle, the write is honoured.
- **Bit 3:** stored and restored like the other bits, never cleared by a branch.
- **flag_we during FLUSH:** honoured. Gating writes from squashed instructions is the pipeline's responsibility.

## Timing
- **Reset:** `rst` high at a clock edge forces:
  - `flags_q` = 0, snapshot = 0, `saved_valid` = 0
  - `branch_taken` = 0, `flush` = 0, `busy` = 0
  - state = IDLE, `cnt` = 0
- **Reset mid-flush:** aborts the flush; all outputs are 0 on the next cycle.
- **Output registration:** all outputs are registered; there are no combinational input-to-output paths.
- **CCR update:** `flag_we` sampled at edge N appears on `flags_q` after edge N, i.e. 1-cycle latency.
- **Taken branch** sampled at edge N:
  - `branch_taken` = 1 for exactly the cycle after edge N.
  - `flush` and `busy` are high for FLUSH_CYCLES cycles, starting that same cycle.
  - The cleared flag is visible on `flags_q` in that same cycle.
- **Back-to-back branches:** the earliest cycle a new branch can be accepted is the first cycle `busy` = 0. Minimum branch-to-branch spacing is FLUSH_CYCLES + 1 cycles.
- **Interrupt save/restore:** each takes effect on `flags_q` / `saved_valid` one cycle after it is sampled.

## Test plan
- **Reset:** drive `rst` for 2 cycles with all other inputs high -> all outputs 0. Then `flag_we` = 1, `alu_flags` = 4'b0101 -> `flags_q` = 4'b0101 one cycle later.
- **JZ taken:** `flags_q` = 4'b0001, JZ with FLUSH_CYCLES = 2 -> `branch_taken` for 1 cycle; `flush` and `busy` for 2 cycles; `flags_q` = 4'b0000. A second JZ presented during FLUSH is ignored: no pulse, and `flags_q` is unchanged.
- **Not taken, then unconditional:** `flags_q` = 4'b0100, JN -> not taken, no flush. JMP on the next cycle -> taken, `flags_q` remains 4'b0100.
- **Clear vs. write:** taken JC with `flag_we` = 1 and `alu_flags` = 4'b0110 in the same cycle -> `flags_q` = 4'b0010.
- **Interrupt save/restore:** `flags_q` = 4'b0011, `int_save` -> `saved_valid` = 1. Write 4'b0000, then `int_restore` -> `flags_q` = 4'b0011 and `saved_valid` = 0. A second `int_restore` with `flag_we` = 0 -> no change.
- **Priority and reset mid-flush:** `int_save` and `int_restore` together with `saved_valid` = 1 -> restore only, snapshot not overwritten. Assert `rst` during the second flush cycle -> `flush` = 0, `flags_q` = 0 on the next cycle.
